// File: rtl/data_array_fill_ctrl_pkg.sv
// Shared widths, FSM encoding and address helper for the data-array
// refill controller.
package data_array_fill_ctrl_pkg;

   localparam int ADDR_WIDTH = 8;
   localparam int WORD_WIDTH = 20;
   localparam int NUM_BLOCKS = 4;
   localparam int LINE_WORDS = 4;
   localparam int OFF_W      = $clog2(LINE_WORDS);
   localparam int SET_W      = ADDR_WIDTH - OFF_W;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FILL = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [OFF_W:0] CNT_FULL = (OFF_W+1)'(LINE_WORDS);

   function automatic logic [ADDR_WIDTH-1:0] line_addr(
      input logic [SET_W-1:0] set,
      input logic [OFF_W-1:0] off
   );
      return {set, off};
   endfunction

endpackage

// File: rtl/data_array_fill_ctrl_rd_hazard.sv
// Combinational read blocker: halt, stale refill words, and
// same-cycle read/write collisions on the array.
module data_array_rd_hazard
   import data_array_fill_ctrl_pkg::*;
(
   input  logic                  halt,
   input  logic                  fill_active,
   input  logic [SET_W-1:0]      fill_set,
   input  logic [NUM_BLOCKS-1:0] fill_way,
   input  logic [LINE_WORDS-1:0] written,
   input  logic                  w_valid,
   input  logic [ADDR_WIDTH-1:0] w_addr,
   input  logic [NUM_BLOCKS-1:0] w_mask,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [NUM_BLOCKS-1:0] rd_mask,
   output logic                  block
);

   logic [SET_W-1:0] rd_set;
   logic [OFF_W-1:0] rd_off;
   logic             stale;
   logic             collide;

   assign rd_set = rd_addr[ADDR_WIDTH-1:OFF_W];
   assign rd_off = rd_addr[OFF_W-1:0];

   // Word of the line being refilled that has not landed yet
   assign stale = fill_active
                && (rd_set == fill_set)
                && (|(rd_mask & fill_way))
                && !written[rd_off];

   assign collide = w_valid
                  && (rd_addr == w_addr)
                  && (|(rd_mask & w_mask));

   assign block = halt | stale | collide;

endmodule

// File: rtl/data_array_fill_ctrl.sv
// Refill sequencer and read arbiter for the 4-way instruction data arrays.
// DATA_ARRAY_FILL_CRITICAL_WORD_FIRST_EN: refill starts at i_fill_word.
module data_array_fill_ctrl
   import data_array_fill_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  i_halt_all,
   input  logic                  i_fill_valid,
   input  logic [SET_W-1:0]      i_fill_set,
   input  logic [NUM_BLOCKS-1:0] i_fill_way,
   input  logic [OFF_W-1:0]      i_fill_word,
   output logic                  o_fill_ready,
   input  logic [WORD_WIDTH-1:0] i_mem_data,
   input  logic                  i_mem_valid,
   output logic                  o_mem_ready,
   output logic                  o_fill_done,
   input  logic [ADDR_WIDTH-1:0] i_rd_addr,
   input  logic                  i_rd_valid,
   input  logic [NUM_BLOCKS-1:0] i_rd_mask,
   output logic                  o_rd_ready,
   output logic [ADDR_WIDTH-1:0] o_r_addr,
   output logic                  o_r_valid,
   output logic [NUM_BLOCKS-1:0] o_r_mask,
   output logic [ADDR_WIDTH-1:0] o_w_addr,
   output logic [WORD_WIDTH-1:0] o_w_data,
   output logic                  o_w_valid,
   output logic [NUM_BLOCKS-1:0] o_w_mask,
   output logic                  o_stop_read_clk,
   output logic                  o_stop_write_clk
);

   logic [1:0]            state_q;
   logic [SET_W-1:0]      set_q;
   logic [NUM_BLOCKS-1:0] way_q;
   logic [OFF_W-1:0]      ptr_q;
   logic [OFF_W-1:0]      ptr_start;
   logic [OFF_W:0]        cnt_q;
   logic [LINE_WORDS-1:0] bitmap_q;
   logic                  line_full;
   logic                  beat;
   logic                  rd_block;

`ifdef DATA_ARRAY_FILL_CRITICAL_WORD_FIRST_EN
   assign ptr_start = i_fill_word;
`else
   logic unused_fill_word;
   assign unused_fill_word = ^i_fill_word;
   assign ptr_start = '0;
`endif

   assign line_full    = (cnt_q == CNT_FULL);
   assign o_mem_ready  = (state_q == ST_FILL)
                       && !line_full && !i_halt_all;
   assign beat         = o_mem_ready && i_mem_valid;
   assign o_fill_ready = (state_q == ST_IDLE) && !i_halt_all;
   assign o_fill_done  = (state_q == ST_DONE);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q   <= ST_IDLE;
         set_q     <= '0;
         way_q     <= '0;
         ptr_q     <= '0;
         cnt_q     <= '0;
         bitmap_q  <= '0;
         o_w_valid <= 1'b0;
         o_w_addr  <= '0;
         o_w_data  <= '0;
         o_w_mask  <= '0;
      end else if (!i_halt_all) begin
         o_w_valid <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (i_fill_valid) begin
                  state_q <= ST_FILL;
                  set_q   <= i_fill_set;
                  way_q   <= i_fill_way;
                  ptr_q   <= ptr_start;
                  cnt_q   <= '0;
               end
            end
            ST_FILL: begin
               if (beat) begin
                  o_w_valid       <= 1'b1;
                  o_w_addr        <= line_addr(set_q, ptr_q);
                  o_w_data        <= i_mem_data;
                  o_w_mask        <= way_q;
                  bitmap_q[ptr_q] <= 1'b1;
                  ptr_q           <= ptr_q + OFF_W'(1);
                  cnt_q           <= cnt_q + (OFF_W+1)'(1);
               end else if (line_full) begin
                  // Last write has been issued; report completion
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               bitmap_q <= '0;
               state_q  <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   data_array_rd_hazard u_rd_hazard (
      .halt        (i_halt_all),
      .fill_active (state_q != ST_IDLE),
      .fill_set    (set_q),
      .fill_way    (way_q),
      .written     (bitmap_q),
      .w_valid     (o_w_valid),
      .w_addr      (o_w_addr),
      .w_mask      (o_w_mask),
      .rd_addr     (i_rd_addr),
      .rd_mask     (i_rd_mask),
      .block       (rd_block)
   );

   assign o_rd_ready       = i_rd_valid && !rd_block;
   assign o_r_valid        = o_rd_ready;
   assign o_r_addr         = i_rd_addr;
   assign o_r_mask         = i_rd_mask;
   assign o_stop_read_clk  = ~o_r_valid;
   assign o_stop_write_clk = ~o_w_valid;

endmodule

// File: tb/tb_data_array_fill_ctrl.sv
// Self-checking bench for data_array_fill_ctrl: directed scenarios plus
// randomized traffic against a line-level refill model.
module tb_data_array_fill_ctrl;
   import data_array_fill_ctrl_pkg::*;

`ifdef DATA_ARRAY_FILL_CRITICAL_WORD_FIRST_EN
   localparam bit CWF = 1'b1;
`else
   localparam bit CWF = 1'b0;
`endif

   logic clk = 1'b0;
   logic arst_n;
   logic i_halt_all, i_fill_valid, i_mem_valid, i_rd_valid;
   logic [SET_W-1:0]      i_fill_set;
   logic [NUM_BLOCKS-1:0] i_fill_way, i_rd_mask;
   logic [OFF_W-1:0]      i_fill_word;
   logic [WORD_WIDTH-1:0] i_mem_data;
   logic [ADDR_WIDTH-1:0] i_rd_addr;
   logic o_fill_ready, o_mem_ready, o_fill_done, o_rd_ready;
   logic o_r_valid, o_w_valid, o_stop_read_clk, o_stop_write_clk;
   logic [ADDR_WIDTH-1:0] o_r_addr, o_w_addr;
   logic [NUM_BLOCKS-1:0] o_r_mask, o_w_mask;
   logic [WORD_WIDTH-1:0] o_w_data;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   data_array_fill_ctrl dut (
      .clk(clk), .arst_n(arst_n), .i_halt_all(i_halt_all),
      .i_fill_valid(i_fill_valid), .i_fill_set(i_fill_set),
      .i_fill_way(i_fill_way), .i_fill_word(i_fill_word),
      .o_fill_ready(o_fill_ready), .i_mem_data(i_mem_data),
      .i_mem_valid(i_mem_valid), .o_mem_ready(o_mem_ready),
      .o_fill_done(o_fill_done), .i_rd_addr(i_rd_addr),
      .i_rd_valid(i_rd_valid), .i_rd_mask(i_rd_mask),
      .o_rd_ready(o_rd_ready), .o_r_addr(o_r_addr),
      .o_r_valid(o_r_valid), .o_r_mask(o_r_mask),
      .o_w_addr(o_w_addr), .o_w_data(o_w_data),
      .o_w_valid(o_w_valid), .o_w_mask(o_w_mask),
      .o_stop_read_clk(o_stop_read_clk),
      .o_stop_write_clk(o_stop_write_clk)
   );

   // Line-level model: a refill is a count of accepted beats plus
   // the set of words already landed, timed in non-halted cycles.
   bit        m_busy;
   int        m_beats, m_start, m_tick, m_last;
   bit        m_wr[LINE_WORDS];
   logic [SET_W-1:0]      m_set;
   logic [NUM_BLOCKS-1:0] m_way;
   bit                    p_v;
   logic [ADDR_WIDTH-1:0] p_a;
   logic [WORD_WIDTH-1:0] p_d;
   logic [NUM_BLOCKS-1:0] p_m;
   bit e_done, e_fill_ready, e_mem_ready, e_rd_ready;

   task automatic model_reset();
      m_busy = 0; m_beats = 0; m_tick = 0; m_last = -10;
      p_v = 0;
      foreach (m_wr[i]) m_wr[i] = 0;
   endtask

   task automatic calc_exp();
      bit stale, coll;
      e_done = m_busy && m_beats == LINE_WORDS
             && m_tick == m_last + 2;
      e_fill_ready = !m_busy && !i_halt_all;
      e_mem_ready = m_busy && m_beats < LINE_WORDS && !i_halt_all;
      stale = m_busy && i_rd_addr[7:2] == m_set
            && (i_rd_mask & m_way) != 0
            && !m_wr[i_rd_addr[1:0]];
      coll = p_v && i_rd_addr == p_a && (i_rd_mask & p_m) != 0;
      e_rd_ready = i_rd_valid && !i_halt_all && !stale && !coll;
   endtask

   task automatic model_update();
      bit was_busy;
      int p;
      if (i_halt_all) return;
      was_busy = m_busy;
      p_v = 0;
      if (m_busy && m_beats < LINE_WORDS && i_mem_valid) begin
         p = (m_start + m_beats) % LINE_WORDS;
         p_v = 1;
         p_a = {m_set, OFF_W'(p)};
         p_d = i_mem_data;
         p_m = m_way;
         m_wr[p] = 1;
         m_beats++;
         if (m_beats == LINE_WORDS) m_last = m_tick;
      end
      if (e_done) begin
         m_busy = 0;
         foreach (m_wr[i]) m_wr[i] = 0;
      end else if (!was_busy && i_fill_valid) begin
         m_busy = 1; m_beats = 0;
         m_set = i_fill_set; m_way = i_fill_way;
         m_start = CWF ? int'(i_fill_word) : 0;
      end
      m_tick++;
   endtask

   task automatic tick_begin();
      @(negedge clk);
      calc_exp();
   endtask

   task automatic tick_end();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_halt_all = 0; i_fill_valid = 0; i_mem_valid = 0;
      i_rd_valid = 0; i_rd_addr = '0; i_rd_mask = '0;
      i_fill_set = '0; i_fill_way = '0; i_fill_word = '0;
      i_mem_data = '0;
   endtask

   task automatic start_fill(input logic [5:0] s, input logic [3:0] w,
                             input logic [1:0] wd);
      i_fill_valid = 1; i_fill_set = s; i_fill_way = w;
      i_fill_word = wd;
   endtask

   // Feed beats until the DUT reports ready again, bounded.
   task automatic drain();
      bit seen_ready = 0;
      i_fill_valid = 0; i_rd_valid = 0; i_halt_all = 0;
      for (int n = 0; n < 40 && !seen_ready; n++) begin
         i_mem_valid = 1;
         i_mem_data = WORD_WIDTH'($urandom);
         tick_begin();
         checks++;
         if (o_fill_done !== e_done) begin
            errors++;
            $display("FAIL drain_done got=%0b want=%0b",
                     o_fill_done, e_done);
         end
         checks++;
         if (o_w_valid !== p_v || (p_v && o_w_addr !== p_a)) begin
            errors++;
            $display("FAIL drain_write got=%0b/%0h want=%0b/%0h",
                     o_w_valid, o_w_addr, p_v, p_a);
         end
         if (o_fill_ready === 1'b1 && !m_busy) seen_ready = 1;
         tick_end();
      end
      i_mem_valid = 0;
      checks++;
      if (!seen_ready) begin
         errors++;
         $display("FAIL drain_timeout got=busy want=ready");
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      arst_n = 0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({o_w_valid, o_w_addr, o_w_data, o_w_mask} !== '0) begin
         errors++;
         $display("FAIL reset_wport got=%0b/%0h/%0h/%0h want=0",
                  o_w_valid, o_w_addr, o_w_data, o_w_mask);
      end
      checks++;
      if ({o_fill_done, o_fill_ready, o_mem_ready} !== 3'b010) begin
         errors++;
         $display("FAIL reset_ctrl got=%b want=010",
                  {o_fill_done, o_fill_ready, o_mem_ready});
      end
      checks++;
      if ({o_stop_write_clk, o_stop_read_clk} !== 2'b11) begin
         errors++;
         $display("FAIL reset_stop got=%b want=11",
                  {o_stop_write_clk, o_stop_read_clk});
      end
      @(posedge clk);
      #1 arst_n = 1;
   endtask

   task automatic run_order(input logic [1:0] wd,
                            input logic [7:0] want[4],
                            input string nm);
      logic [7:0] seen[$];
      int done_at = -1, rdy_at = -1;
      start_fill(6'h05, 4'b0010, wd);
      for (int c = 0; c < 9; c++) begin
         if (c > 0) i_fill_valid = 0;
         i_mem_valid = (c >= 1 && c <= 4);
         i_mem_data = WORD_WIDTH'(32'hA0 + c - 1);
         tick_begin();
         if (o_w_valid === 1'b1) seen.push_back(o_w_addr);
         checks++;
         if (o_w_valid !== p_v || (p_v && o_w_data !== p_d)) begin
            errors++;
            $display("FAIL %s_wdata c%0d got=%0b/%0h want=%0b/%0h",
                     nm, c, o_w_valid, o_w_data, p_v, p_d);
         end
         if (o_fill_done === 1'b1 && done_at < 0) done_at = c;
         if (c > 0 && o_fill_ready === 1'b1 && rdy_at < 0) rdy_at = c;
         tick_end();
      end
      checks++;
      if (seen.size() != 4 || seen[0] !== want[0] || seen[1] !== want[1]
          || seen[2] !== want[2] || seen[3] !== want[3]) begin
         errors++;
         $display("FAIL %s_order got=%p want=%p", nm, seen, want);
      end
      checks++;
      if (done_at != 6 || rdy_at != 7) begin
         errors++;
         $display("FAIL %s_timing got=done%0d/rdy%0d want=done6/rdy7",
                  nm, done_at, rdy_at);
      end
   endtask

   task automatic test_basic_fill();
      logic [7:0] want[4];
      want = '{8'h14, 8'h15, 8'h16, 8'h17};
      run_order(2'd0, want, "basic");
   endtask

   task automatic test_critical_word();
      logic [7:0] want[4];
      if (CWF) want = '{8'h16, 8'h17, 8'h14, 8'h15};
      else     want = '{8'h14, 8'h15, 8'h16, 8'h17};
      run_order(2'd2, want, "cwf");
   endtask

   task automatic test_stale_read();
      logic [7:0] ra[6] = '{8'h00, 8'h00, 8'h00, 8'h15, 8'h14, 8'h15};
      logic [3:0] rm[6] = '{4'h0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h1};
      bit want[6] = '{0, 0, 0, 0, 1, 1};
      start_fill(6'h05, 4'b0010, 2'd0);
      for (int c = 0; c < 6; c++) begin
         if (c > 0) i_fill_valid = 0;
         i_mem_valid = (c == 1);
         i_rd_valid = (c >= 3);
         i_rd_addr = ra[c]; i_rd_mask = rm[c];
         tick_begin();
         if (c >= 3) begin
            checks++;
            if (o_rd_ready !== want[c] || o_r_valid !== want[c]
                || o_rd_ready !== e_rd_ready) begin
               errors++;
               $display("FAIL stale_rd c%0d got=%0b want=%0b",
                        c, o_rd_ready, want[c]);
            end
         end
         tick_end();
      end
      drain();
   endtask

   task automatic test_collision();
      start_fill(6'h0A, 4'b0100, 2'd0);
      for (int c = 0; c < 4; c++) begin
         if (c > 0) i_fill_valid = 0;
         i_mem_valid = (c == 1);
         i_rd_valid = (c >= 2);
         i_rd_addr = 8'h28; i_rd_mask = 4'b0100;
         tick_begin();
         if (c >= 2) begin
            checks++;
            if (o_rd_ready !== (c == 3) || o_stop_read_clk !== (c == 2))
            begin
               errors++;
               $display("FAIL collide c%0d got=%0b want=%0b",
                        c, o_rd_ready, c == 3);
            end
         end
         tick_end();
      end
      drain();
   endtask

   task automatic test_bubbles_halt();
      bit mv[9] = '{0, 1, 0, 1, 1, 1, 1, 1, 1};
      bit hv[9] = '{0, 0, 0, 0, 1, 1, 1, 0, 0};
      start_fill(6'h21, 4'b0001, 2'd1);
      for (int c = 0; c < 9; c++) begin
         if (c > 0) i_fill_valid = 0;
         i_mem_valid = mv[c]; i_halt_all = hv[c];
         i_mem_data = WORD_WIDTH'($urandom);
         i_rd_valid = 1; i_rd_addr = 8'h00; i_rd_mask = 4'b1000;
         tick_begin();
         checks++;
         if (o_w_valid !== p_v || o_stop_write_clk !== !p_v
             || (p_v && (o_w_addr !== p_a || o_w_data !== p_d))) begin
            errors++;
            $display("FAIL bubble_w c%0d got=%0b/%0h want=%0b/%0h",
                     c, o_w_valid, o_w_addr, p_v, p_a);
         end
         if (c == 3) begin
            checks++;
            if (o_w_valid !== 1'b0 || o_stop_write_clk !== 1'b1) begin
               errors++;
               $display("FAIL bubble_gap got=%0b want=0", o_w_valid);
            end
         end
         if (hv[c]) begin
            checks++;
            if (o_mem_ready !== 1'b0 || o_rd_ready !== 1'b0
                || o_w_valid !== 1'b1) begin
               errors++;
               $display("FAIL halt_hold c%0d got=%b want=001", c,
                        {o_mem_ready, o_rd_ready, o_w_valid});
            end
         end
         checks++;
         if (o_mem_ready !== e_mem_ready) begin
            errors++;
            $display("FAIL bubble_mrdy c%0d got=%0b want=%0b",
                     c, o_mem_ready, e_mem_ready);
         end
         tick_end();
      end
      i_rd_valid = 0;
      drain();
   endtask

   task automatic test_reset_mid_fill();
      start_fill(6'h03, 4'b1000, 2'd0);
      for (int c = 0; c < 3; c++) begin
         if (c > 0) i_fill_valid = 0;
         i_mem_valid = (c >= 1);
         tick_begin();
         tick_end();
      end
      i_mem_valid = 0;
      @(negedge clk);
      arst_n = 0;
      #1;
      model_reset();
      checks++;
      if (o_w_valid !== 1'b0 || o_fill_ready !== 1'b1
          || o_mem_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid got=%b want=010",
                  {o_w_valid, o_fill_ready, o_mem_ready});
      end
      @(posedge clk);
      #1 arst_n = 1;
      start_fill(6'h03, 4'b1000, 2'd0);
      for (int c = 0; c < 2; c++) begin
         if (c > 0) i_fill_valid = 0;
         i_rd_valid = (c == 1); i_rd_addr = 8'h0D;
         i_rd_mask = 4'b1000;
         tick_begin();
         if (c == 1) begin
            checks++;
            if (o_rd_ready !== 1'b0) begin
               errors++;
               $display("FAIL rst_bitmap got=%0b want=0", o_rd_ready);
            end
         end
         tick_end();
      end
      drain();
   endtask

   task automatic test_random();
      logic [5:0] pool[2] = '{6'h05, 6'h2C};
      for (int c = 0; c < 1500; c++) begin
         i_halt_all   = ($urandom_range(15) == 0);
         i_fill_valid = ($urandom_range(3) == 0);
         i_fill_set   = pool[$urandom_range(1)];
         i_fill_way   = 4'b0001 << $urandom_range(3);
         i_fill_word  = OFF_W'($urandom);
         i_mem_valid  = ($urandom_range(2) != 0);
         i_mem_data   = WORD_WIDTH'($urandom);
         i_rd_valid   = $urandom_range(1);
         i_rd_addr    = {pool[$urandom_range(1)], OFF_W'($urandom)};
         i_rd_mask    = 4'b0001 << $urandom_range(3);
         tick_begin();
         checks++;
         if (o_w_valid !== p_v || o_stop_write_clk !== !p_v) begin
            errors++;
            $display("FAIL rnd_wvalid c%0d got=%0b want=%0b",
                     c, o_w_valid, p_v);
         end
         checks++;
         if (p_v && (o_w_addr !== p_a || o_w_data !== p_d
                     || o_w_mask !== p_m)) begin
            errors++;
            $display("FAIL rnd_wpay c%0d got=%0h/%0h/%0h want=%0h/%0h/%0h",
                     c, o_w_addr, o_w_data, o_w_mask, p_a, p_d, p_m);
         end
         checks++;
         if (o_fill_done !== e_done || o_fill_ready !== e_fill_ready
             || o_mem_ready !== e_mem_ready) begin
            errors++;
            $display("FAIL rnd_ctrl c%0d got=%b want=%b", c,
                     {o_fill_done, o_fill_ready, o_mem_ready},
                     {e_done, e_fill_ready, e_mem_ready});
         end
         checks++;
         if (o_rd_ready !== e_rd_ready || o_r_valid !== e_rd_ready
             || o_stop_read_clk !== !e_rd_ready) begin
            errors++;
            $display("FAIL rnd_rd c%0d got=%0b want=%0b",
                     c, o_rd_ready, e_rd_ready);
         end
         tick_end();
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_basic_fill();
      test_critical_word();
      test_stale_read();
      test_collision();
      test_bubbles_halt();
      test_reset_mid_fill();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
